// File: rtl/ps2_host_tx_pkg.sv
// Shared PS/2 definitions: transmitter states, keyboard command bytes, LED mask layout.
package ps2_pkg;

    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned FRAME_W = 11;

    // Host transmitter states
    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        SEND,
        ACK,
        RECOVER
    } state_e;

    // Keyboard command / response bytes
    localparam logic [BYTE_W-1:0] CMD_SET_LED = 8'hED;
    localparam logic [BYTE_W-1:0] CMD_RESET   = 8'hFF;
    localparam logic [BYTE_W-1:0] RSP_ACK     = 8'hFA;
    localparam logic [BYTE_W-1:0] BRK_F0      = 8'hF0;

    // Bit positions inside the 0xED LED mask byte
    localparam int unsigned LED_SCROLL = 0;
    localparam int unsigned LED_NUM    = 1;
    localparam int unsigned LED_CAPS   = 2;

    // Odd parity bit: set when the byte holds an even number of ones
    function automatic logic odd_parity(input logic [BYTE_W-1:0] d);
        return ~^d;
    endfunction

    // Build the LED mask byte that follows CMD_SET_LED
    function automatic logic [BYTE_W-1:0] led_mask(input logic caps,
                                                   input logic num,
                                                   input logic scroll);
        logic [BYTE_W-1:0] m;
        m             = '0;
        m[LED_CAPS]   = caps;
        m[LED_NUM]    = num;
        m[LED_SCROLL] = scroll;
        return m;
    endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Byte-level request/status handshake between a command source and ps2_host_tx.
interface ps2_host_tx_if;
    import ps2_pkg::*;

    logic              tx_valid;
    logic [BYTE_W-1:0] tx_data;
    logic              tx_ready;
    logic              tx_done;
    logic              tx_err;
    logic              busy;

    // Command source side
    modport master (
        output tx_valid,
        output tx_data,
        input  tx_ready,
        input  tx_done,
        input  tx_err,
        input  busy
    );

    // Transmitter side
    modport slave (
        input  tx_valid,
        input  tx_data,
        output tx_ready,
        output tx_done,
        output tx_err,
        output busy
    );
endinterface

// File: rtl/ps2_host_tx_sync_edge.sv
// ps2_sync_edge: 2-flop synchronizer for an asynchronous PS/2 pad plus a
// registered falling-edge strobe. The strobe compares the synchronized value
// with the one about to replace it, so it rises in the same cycle that sync
// goes low (pad edge to strobe = 2 clk_50 edges).
module ps2_sync_edge (
    input  logic clk_50,
    input  logic reset,
    input  logic pad,
    output logic sync,
    output logic fall
);

    logic meta;

    // Pads idle high, so reset to the idle level to avoid a false fall strobe
    always_ff @(posedge clk_50) begin
        if (reset) begin
            meta <= 1'b1;
            sync <= 1'b1;
            fall <= 1'b0;
        end else begin
            meta <= pad;
            sync <= meta;
            fall <= sync & ~meta;
        end
    end

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 transmitter. Inhibits the bus, issues the
// start bit, shifts out 8 data bits LSB first, odd parity and stop on device
// clock falls, then samples the device ack bit.
// Optional build macro PS2_TX_TIMEOUT_EN enables the TIMEOUT_CYCLES watchdog
// in SEND/ACK/RECOVER; without it a silent device parks the block until reset.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned TIMEOUT_CYCLES = 750000,
    parameter int unsigned TMR_W          = 20
) (
    input  logic          clk_50,
    input  logic          reset,
    ps2_host_tx_if.slave  tx,
    input  logic          ps2_clk_in,
    input  logic          ps2_data_in,
    output logic          ps2_clk_oe,
    output logic          ps2_data_oe
);

    localparam int unsigned TMR_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ?
                                      INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam logic [TMR_W-1:0] TMR_SAT       = TMR_W'(TMR_MAX);
    localparam logic [TMR_W-1:0] INH_LAST      = TMR_W'(INHIBIT_CYCLES - 1);
    localparam logic [TMR_W-1:0] INH_START_BIT = TMR_W'(INHIBIT_CYCLES - 2);
    localparam logic [3:0]       LAST_DATA_BIT = 4'd7;
    localparam logic [3:0]       PARITY_BIT    = 4'd8;

    state_e            state;
    logic [TMR_W-1:0]  timer;
    logic [3:0]        bitcnt;
    logic [BYTE_W-1:0] data_q;
    logic              par_q;
    logic              tx_ready_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;
    logic              clk_oe_q;
    logic              data_oe_q;

    logic              clk_sync;
    logic              clk_fall;
    logic              data_sync;
    logic              data_fall_unused;

    logic [TMR_W-1:0]  timer_inc_c;
    logic              wd_expired_c;

    // Pad conditioning, one synchronizer per line
    ps2_sync_edge u_clk_sync (
        .clk_50 (clk_50),
        .reset  (reset),
        .pad    (ps2_clk_in),
        .sync   (clk_sync),
        .fall   (clk_fall)
    );

    ps2_sync_edge u_data_sync (
        .clk_50 (clk_50),
        .reset  (reset),
        .pad    (ps2_data_in),
        .sync   (data_sync),
        .fall   (data_fall_unused)
    );

    // Saturating timer increment; never wraps back to zero
    assign timer_inc_c = (timer == TMR_SAT) ? timer : timer + TMR_W'(1);

`ifdef PS2_TX_TIMEOUT_EN
    // Watchdog on the gap between device clock falls
    assign wd_expired_c = (timer == TMR_W'(TIMEOUT_CYCLES));
`else
    assign wd_expired_c = 1'b0;
`endif

    // Transfer sequencer: all outputs registered
    always_ff @(posedge clk_50) begin
        if (reset) begin
            state      <= IDLE;
            timer      <= '0;
            bitcnt     <= '0;
            data_q     <= '0;
            par_q      <= 1'b0;
            tx_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            clk_oe_q   <= 1'b0;
            data_oe_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state)
                IDLE: begin
                    clk_oe_q   <= 1'b0;
                    data_oe_q  <= 1'b0;
                    tx_ready_q <= 1'b1;
                    busy_q     <= 1'b0;
                    if (tx.tx_valid && tx_ready_q) begin
                        data_q     <= tx.tx_data;
                        par_q      <= odd_parity(tx.tx_data);
                        tx_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        clk_oe_q   <= 1'b1;
                        timer      <= '0;
                        state      <= INHIBIT;
                    end
                end

                INHIBIT: begin
                    timer <= timer_inc_c;
                    // Start bit goes out in the last inhibit cycle
                    if (timer == INH_START_BIT) begin
                        data_oe_q <= 1'b1;
                    end
                    if (timer == INH_LAST) begin
                        clk_oe_q  <= 1'b0;
                        data_oe_q <= 1'b1;
                        bitcnt    <= '0;
                        timer     <= '0;
                        state     <= SEND;
                    end
                end

                SEND: begin
                    if (clk_fall) begin
                        timer  <= '0;
                        bitcnt <= bitcnt + 4'd1;
                        if (bitcnt <= LAST_DATA_BIT) begin
                            data_oe_q <= ~data_q[bitcnt[2:0]];
                        end else if (bitcnt == PARITY_BIT) begin
                            data_oe_q <= ~par_q;
                        end else begin
                            // Stop bit: release data and let the device ack
                            data_oe_q <= 1'b0;
                            state     <= ACK;
                        end
                    end else if (wd_expired_c) begin
                        clk_oe_q   <= 1'b0;
                        data_oe_q  <= 1'b0;
                        err_q      <= 1'b1;
                        tx_ready_q <= 1'b1;
                        busy_q     <= 1'b0;
                        timer      <= '0;
                        state      <= IDLE;
                    end else begin
                        timer <= timer_inc_c;
                    end
                end

                ACK: begin
                    if (clk_fall) begin
                        timer <= '0;
                        if (!data_sync) begin
                            done_q <= 1'b1;
                        end else begin
                            err_q <= 1'b1;
                        end
                        state <= RECOVER;
                    end else if (wd_expired_c) begin
                        clk_oe_q   <= 1'b0;
                        data_oe_q  <= 1'b0;
                        err_q      <= 1'b1;
                        tx_ready_q <= 1'b1;
                        busy_q     <= 1'b0;
                        timer      <= '0;
                        state      <= IDLE;
                    end else begin
                        timer <= timer_inc_c;
                    end
                end

                RECOVER: begin
                    // Wait for the device to let both lines float high
                    if (clk_sync && data_sync) begin
                        tx_ready_q <= 1'b1;
                        busy_q     <= 1'b0;
                        timer      <= '0;
                        state      <= IDLE;
                    end else if (wd_expired_c) begin
                        clk_oe_q   <= 1'b0;
                        data_oe_q  <= 1'b0;
                        err_q      <= 1'b1;
                        tx_ready_q <= 1'b1;
                        busy_q     <= 1'b0;
                        timer      <= '0;
                        state      <= IDLE;
                    end else begin
                        timer <= timer_inc_c;
                    end
                end

                default: begin
                    clk_oe_q  <= 1'b0;
                    data_oe_q <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    assign tx.tx_ready  = tx_ready_q;
    assign tx.tx_done   = done_q;
    assign tx.tx_err    = err_q;
    assign tx.busy      = busy_q;
    assign ps2_clk_oe   = clk_oe_q;
    assign ps2_data_oe  = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain pad model plus a PS/2 device model that
// clocks the frame in, captures it and optionally acks. Random command bytes
// are compared against frames built from the protocol rules.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int unsigned INH  = 20;
    localparam int unsigned TMO  = 2000;
    localparam int unsigned HALF = 20;

    logic clk_50;
    logic reset;
    logic ps2_clk_in;
    logic ps2_data_in;
    logic ps2_clk_oe;
    logic ps2_data_oe;
    logic dev_clk_low;
    logic dev_data_low;

    int n_checks = 0;
    int n_errors = 0;
    int unsigned cyc = 0;
    int unsigned last_fall_cyc = 0;

    int  done_hi = 0;
    int  err_hi = 0;
    int  xfer_cnt = 0;
    logic clk_oe_prev = 1'b0;
    logic both_seen = 1'b0;
    logic watch_ready = 1'b0;
    logic ready_glitch = 1'b0;

    ps2_host_tx_if tx_if ();

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TMO),
        .TMR_W          (12)
    ) dut (
        .clk_50      (clk_50),
        .reset       (reset),
        .tx          (tx_if),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe)
    );

    // Open-drain lines with pull-ups
    assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

    initial clk_50 = 1'b0;
    always #10 clk_50 = ~clk_50;

    always @(posedge clk_50) cyc <= cyc + 1;

    // Pulse and transfer bookkeeping
    always @(negedge clk_50) begin
        if (tx_if.tx_done) done_hi <= done_hi + 1;
        if (tx_if.tx_err)  err_hi  <= err_hi + 1;
        if (tx_if.tx_done && tx_if.tx_err) both_seen <= 1'b1;
        if (ps2_clk_oe && !clk_oe_prev) xfer_cnt <= xfer_cnt + 1;
        clk_oe_prev <= ps2_clk_oe;
        if (watch_ready && tx_if.tx_ready) ready_glitch <= 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_50);
        #1;
    endtask

    // Reference frame: start 0, data LSB first, odd parity, stop 1
    function automatic logic [10:0] exp_frame(input logic [7:0] b);
        logic [10:0] f;
        int ones;
        ones = 0;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            f[i+1] = ((b >> i) & 8'd1) != 8'd0;
            if (f[i+1]) ones++;
        end
        f[9]  = (ones % 2) == 0;
        f[10] = 1'b1;
        return f;
    endfunction

    task automatic wait_ready(input string tag, input int bound);
        int n;
        n = 0;
        while (!tx_if.tx_ready && n < bound) begin
            tick();
            n++;
        end
        chk({tag, "_ready"}, 32'(tx_if.tx_ready), 32'd1);
    endtask

    task automatic send(input logic [7:0] b, input string tag);
        wait_ready(tag, 500);
        tx_if.tx_valid = 1'b1;
        tx_if.tx_data  = b;
        tick();
        tx_if.tx_valid = 1'b0;
    endtask

    // Device model: measures the inhibit, clocks n_falls bits in, optional ack
    task automatic dev_xfer(input string tag, input int n_falls, input bit give_ack,
                            output logic [10:0] frame);
        int n;
        frame = '1;
        n = 0;
        while (!ps2_clk_oe && n < 200) begin
            tick();
            n++;
        end
        chk({tag, "_inh_seen"}, 32'(ps2_clk_oe), 32'd1);
        n = 0;
        while (ps2_clk_oe && n < 200) begin
            tick();
            n++;
        end
        chk({tag, "_inh_len"}, 32'(n), 32'(INH));
        frame[0] = ps2_data_in;
        for (int i = 1; i <= n_falls; i++) begin
            repeat (HALF) tick();
            dev_clk_low   = 1'b1;
            last_fall_cyc = cyc;
            repeat (HALF) tick();
            frame[i]    = ps2_data_in;
            dev_clk_low = 1'b0;
        end
        if (n_falls == 10) begin
            repeat (HALF / 2) tick();
            if (give_ack) dev_data_low = 1'b1;
            repeat (HALF / 2) tick();
            dev_clk_low = 1'b1;
            repeat (HALF) tick();
            dev_clk_low  = 1'b0;
            dev_data_low = 1'b0;
        end
    endtask

    task automatic run_xfer(input logic [7:0] b, input bit ack, input string tag);
        int d0, e0;
        logic [10:0] frame;
        d0 = done_hi;
        e0 = err_hi;
        send(b, tag);
        dev_xfer(tag, 10, ack, frame);
        chk({tag, "_frame"}, 32'(frame), 32'(exp_frame(b)));
        wait_ready(tag, 200);
        chk({tag, "_idle_lines"}, 32'({ps2_clk_in, ps2_data_in}), 32'd3);
        chk({tag, "_done"}, 32'(done_hi - d0), ack ? 32'd1 : 32'd0);
        chk({tag, "_err"},  32'(err_hi - e0),  ack ? 32'd0 : 32'd1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        tick();
    endtask

    initial begin : stim
        logic [10:0] frame;
        logic [7:0]  b;
        bit          ack;
        int          d0, e0, x0, el, n;

        reset          = 1'b1;
        tx_if.tx_valid = 1'b0;
        tx_if.tx_data  = '0;
        dev_clk_low    = 1'b0;
        dev_data_low   = 1'b0;

        // Reset state
        repeat (3) tick();
        chk("rst_clk_oe",  32'(ps2_clk_oe), 32'd0);
        chk("rst_data_oe", 32'(ps2_data_oe), 32'd0);
        chk("rst_ready",   32'(tx_if.tx_ready), 32'd0);
        chk("rst_busy",    32'(tx_if.busy), 32'd0);
        chk("rst_done",    32'(tx_if.tx_done), 32'd0);
        chk("rst_err",     32'(tx_if.tx_err), 32'd0);
        reset = 1'b0;
        tick();
        chk("post_rst_ready", 32'(tx_if.tx_ready), 32'd1);
        chk("post_rst_busy",  32'(tx_if.busy), 32'd0);

        // Directed frames and parity corners
        run_xfer(CMD_SET_LED, 1'b1, "ed");
        send(8'h00, "p00");
        dev_xfer("p00", 10, 1'b1, frame);
        chk("p00_par", 32'(frame[9]), 32'd1);
        chk("p00_frame", 32'(frame), 32'(exp_frame(8'h00)));
        wait_ready("p00", 200);
        send(8'h01, "p01");
        dev_xfer("p01", 10, 1'b1, frame);
        chk("p01_par", 32'(frame[9]), 32'd0);
        chk("p01_frame", 32'(frame), 32'(exp_frame(8'h01)));
        wait_ready("p01", 200);

        // Missing ack
        run_xfer(led_mask(1'b1, 1'b0, 1'b1), 1'b0, "noack");

        // Randomized bytes and ack behaviour
        for (int t = 0; t < 8; t++) begin
            b   = 8'($urandom);
            ack = 1'($urandom_range(0, 3) != 0);
            run_xfer(b, ack, "rnd");
        end

        // Device stops clocking after bit 3
        d0 = done_hi;
        e0 = err_hi;
        send(8'hA7, "stall");
        dev_xfer("stall", 4, 1'b0, frame);
`ifdef PS2_TX_TIMEOUT_EN
        n = 0;
        while (!tx_if.tx_err && n < 2500) begin
            tick();
            n++;
        end
        el = int'(cyc - last_fall_cyc);
        chk("wd_fired", 32'(tx_if.tx_err), 32'd1);
        chk("wd_window", 32'(el >= 2000 && el <= 2010), 32'd1);
        tick();
        chk("wd_oe", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
        wait_ready("wd", 10);
        chk("wd_done", 32'(done_hi - d0), 32'd0);
        chk("wd_err",  32'(err_hi - e0), 32'd1);
`else
        el = 0;
        n  = 0;
        repeat (3000) tick();
        chk("stall_busy", 32'(tx_if.busy), 32'd1);
        chk("stall_ready", 32'(tx_if.tx_ready), 32'd0);
        chk("stall_err", 32'(err_hi - e0), 32'd0);
        chk("stall_done", 32'(done_hi - d0), 32'd0);
        do_reset();
`endif

        // Reset in the middle of bit 5 (bit 5 of 0x5A is 0, so data is pulled)
        d0 = done_hi;
        e0 = err_hi;
        send(8'h5A, "mid");
        dev_xfer("mid", 6, 1'b0, frame);
        chk("mid_data_pulled", 32'(ps2_data_oe), 32'd1);
        reset = 1'b1;
        tick();
        chk("mid_rst_oe", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
        chk("mid_rst_busy", 32'(tx_if.busy), 32'd0);
        reset = 1'b0;
        tick();
        chk("mid_ready", 32'(tx_if.tx_ready), 32'd1);
        chk("mid_no_pulse", 32'((done_hi - d0) + (err_hi - e0)), 32'd0);
        run_xfer(CMD_RESET, 1'b1, "ff");

        // tx_valid held with another byte while busy
        x0 = xfer_cnt;
        wait_ready("hold", 200);
        tx_if.tx_valid = 1'b1;
        tx_if.tx_data  = 8'h3C;
        tick();
        tx_if.tx_data  = 8'h55;
        watch_ready    = 1'b1;
        dev_xfer("hold", 10, 1'b1, frame);
        tx_if.tx_valid = 1'b0;
        watch_ready    = 1'b0;
        chk("hold_frame", 32'(frame), 32'(exp_frame(8'h3C)));
        chk("hold_ready_low", 32'(ready_glitch), 32'd0);
        wait_ready("hold", 200);
        repeat (60) tick();
        chk("hold_one_xfer", 32'(xfer_cnt - x0), 32'd1);

        chk("never_both", 32'(both_seen), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
